// File: rtl/sargantana_icache_repl_pkg.sv
// Shared types and helpers for the icache victim-way selector: policy/state
// enums, LFSR tap masks and tree pseudo-LRU walk/update functions.
package sargantana_icache_repl_pkg;

   typedef enum logic {
      REPL_LFSR = 1'b0,
      REPL_PLRU = 1'b1
   } repl_policy_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_OFFER = 1'b1
   } repl_state_e;

   // Tree helpers work on a fixed-size node vector so any way count up to 64 fits.
   localparam int unsigned PLRU_MAX_LVL   = 6;
   localparam int unsigned PLRU_MAX_NODES = 63;

   function automatic logic [15:0] lfsr_taps(input int unsigned width);
      logic [15:0] taps;
      case (width)
         4:       taps = 16'h000C;
         8:       taps = 16'h00B8;
         12:      taps = 16'h0829;
         16:      taps = 16'hD008;
         default: taps = 16'h0000;
      endcase
      return taps;
   endfunction

   function automatic logic [PLRU_MAX_LVL-1:0] plru_victim(
      input logic [PLRU_MAX_NODES-1:0] nodes,
      input int unsigned               n_way
   );
      logic [PLRU_MAX_LVL-1:0] idx;
      logic [PLRU_MAX_LVL-1:0] way;
      logic                    b;
      idx = '0;
      way = '0;
      b   = 1'b0;
      for (int unsigned l = 0; l < PLRU_MAX_LVL; l++) begin
         if (l < $clog2(n_way)) begin
            b   = nodes[idx];
            way = {way[PLRU_MAX_LVL-2:0], b};
            idx = {idx[PLRU_MAX_LVL-2:0], 1'b0} + {{(PLRU_MAX_LVL-1){1'b0}}, 1'b1}
                  + {{(PLRU_MAX_LVL-1){1'b0}}, b};
         end
      end
      return way;
   endfunction

   // Each node on the path is made to point at the sibling subtree of the access.
   function automatic logic [PLRU_MAX_NODES-1:0] plru_update(
      input logic [PLRU_MAX_NODES-1:0] nodes,
      input logic [PLRU_MAX_LVL-1:0]   way,
      input int unsigned               n_way
   );
      logic [PLRU_MAX_NODES-1:0] res;
      logic [PLRU_MAX_LVL-1:0]   idx;
      logic [PLRU_MAX_LVL-1:0]   path;
      logic                      d;
      res  = nodes;
      idx  = '0;
      d    = 1'b0;
      path = way << (PLRU_MAX_LVL - $clog2(n_way));
      for (int unsigned l = 0; l < PLRU_MAX_LVL; l++) begin
         if (l < $clog2(n_way)) begin
            d        = path[PLRU_MAX_LVL-1];
            path     = path << 1;
            res[idx] = ~d;
            idx      = {idx[PLRU_MAX_LVL-2:0], 1'b0} + {{(PLRU_MAX_LVL-1){1'b0}}, 1'b1}
                       + {{(PLRU_MAX_LVL-1){1'b0}}, d};
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/sargantana_icache_lfsr_n.sv
// Fibonacci XNOR LFSR, shift-left with feedback into bit 0; steps only when en_i.
module sargantana_icache_lfsr_n
   import sargantana_icache_repl_pkg::*;
#(
   parameter int unsigned      WIDTH = 8,
   parameter logic [WIDTH-1:0] SEED  = '0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   output logic [WIDTH-1:0] state_o
);

   localparam logic [15:0]      TAPS_FULL = lfsr_taps(WIDTH);
   localparam logic [WIDTH-1:0] TAPS      = TAPS_FULL[WIDTH-1:0];

   logic [WIDTH-1:0] state_q;
   logic             fb;

   // XNOR feedback keeps all-zero legal; all-ones is the lock-up state.
   assign fb = ~^(state_q & TAPS);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= SEED;
      end else if (en_i) begin
         state_q <= {state_q[WIDTH-2:0], fb};
      end
   end

   assign state_o = state_q;

endmodule

// File: rtl/sargantana_icache_replace.sv
// Icache victim-way selector: invalid-first, then LFSR or per-set tree PLRU,
// answered with a registered offer held until the refill FSM commits it.
//
//   state    | meaning
//   ST_IDLE  | no offer outstanding; a refill request captures a victim
//   ST_OFFER | refill_valid_o high, way/set held until commit or flush
module sargantana_icache_replace
   import sargantana_icache_repl_pkg::*;
#(
   parameter int unsigned ICACHE_N_WAY  = 4,
   parameter int unsigned ICACHE_N_SETS = 64,
   parameter int unsigned REPL_POLICY   = 0,
   parameter int unsigned LFSR_WIDTH    = 8,
   parameter int unsigned LFSR_SEED     = 0,
   localparam int unsigned WAY_W = $clog2(ICACHE_N_WAY),
   localparam int unsigned SET_W = $clog2(ICACHE_N_SETS)
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    flush_i,
   input  logic                    hit_valid_i,
   input  logic [SET_W-1:0]        hit_set_i,
   input  logic [WAY_W-1:0]        hit_way_i,
   input  logic                    refill_req_i,
   input  logic [SET_W-1:0]        refill_set_i,
   input  logic [ICACHE_N_WAY-1:0] valid_ways_i,
   output logic                    refill_valid_o,
   output logic [WAY_W-1:0]        refill_way_o,
   input  logic                    refill_commit_i
);

   localparam int unsigned LFSR_MASK = (1 << LFSR_WIDTH) - 1;

   if (ICACHE_N_WAY < 2 || ICACHE_N_WAY > 64 || (ICACHE_N_WAY & (ICACHE_N_WAY - 1)) != 0) begin : g_bad_ways
      $fatal(1, "ICACHE_N_WAY must be a power of two in [2,64]");
   end
   if (LFSR_WIDTH != 4 && LFSR_WIDTH != 8 && LFSR_WIDTH != 12 && LFSR_WIDTH != 16) begin : g_bad_width
      $fatal(1, "LFSR_WIDTH must be 4, 8, 12 or 16");
   end
   if (LFSR_WIDTH < WAY_W) begin : g_short_lfsr
      $fatal(1, "LFSR_WIDTH too small for ICACHE_N_WAY");
   end
   if ((LFSR_SEED & LFSR_MASK) == LFSR_MASK) begin : g_bad_seed
      $fatal(1, "LFSR_SEED must not be all-ones");
   end

   repl_state_e            state_q, state_d;
   logic [WAY_W-1:0]       way_q, way_d;
   logic [SET_W-1:0]       set_q, set_d;
   logic                   commit_fire;
   logic                   req_fire;
   logic [LFSR_WIDTH-1:0]  lfsr_state;
   logic [WAY_W-1:0]       inv_way;
   logic [WAY_W-1:0]       lfsr_way;
   logic [WAY_W-1:0]       plru_way;
   logic [WAY_W-1:0]       victim_way;
   logic                   all_valid;
   logic                   unused_lfsr;

   assign commit_fire = (state_q == ST_OFFER) && refill_commit_i && !flush_i;
   assign req_fire    = (state_q == ST_IDLE) && refill_req_i && !flush_i;

   sargantana_icache_lfsr_n #(
      .WIDTH (LFSR_WIDTH),
      .SEED  (LFSR_WIDTH'(LFSR_SEED))
   ) u_lfsr (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .en_i    (commit_fire),
      .state_o (lfsr_state)
   );

   assign lfsr_way    = lfsr_state[WAY_W-1:0];
   assign unused_lfsr = ^lfsr_state;

   // Descending scan leaves the lowest-index invalid way.
   always_comb begin
      inv_way = '0;
      for (int i = ICACHE_N_WAY - 1; i >= 0; i--) begin
         if (!valid_ways_i[i]) inv_way = WAY_W'(i);
      end
   end

   assign all_valid  = &valid_ways_i;
   assign victim_way = !all_valid ? inv_way :
                       (REPL_POLICY == int'(REPL_PLRU)) ? plru_way : lfsr_way;

   always_comb begin
      state_d = state_q;
      way_d   = way_q;
      set_d   = set_q;
      if (flush_i) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_fire) begin
                  state_d = ST_OFFER;
                  way_d   = victim_way;
                  set_d   = refill_set_i;
               end
            end
            ST_OFFER: begin
               if (commit_fire) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         way_q   <= '0;
         set_q   <= '0;
      end else begin
         state_q <= state_d;
         way_q   <= way_d;
         set_q   <= set_d;
      end
   end

   assign refill_valid_o = (state_q == ST_OFFER);
   assign refill_way_o   = way_q;

   if (REPL_POLICY == int'(REPL_PLRU)) begin : g_plru
      logic [ICACHE_N_WAY-2:0]   plru_q [ICACHE_N_SETS];
      logic [PLRU_MAX_NODES-1:0] vic_nodes, hit_nodes, com_nodes;
      logic [PLRU_MAX_NODES-1:0] hit_upd, com_upd;
      logic [PLRU_MAX_LVL-1:0]   vic_ext;
      logic                      hit_apply;
      logic                      unused_plru;

      always_comb begin
         vic_nodes = '0;
         hit_nodes = '0;
         com_nodes = '0;
         vic_nodes[ICACHE_N_WAY-2:0] = plru_q[refill_set_i];
         hit_nodes[ICACHE_N_WAY-2:0] = plru_q[hit_set_i];
         com_nodes[ICACHE_N_WAY-2:0] = plru_q[set_q];
         vic_ext = plru_victim(vic_nodes, ICACHE_N_WAY);
         hit_upd = plru_update(hit_nodes, PLRU_MAX_LVL'(hit_way_i), ICACHE_N_WAY);
         com_upd = plru_update(com_nodes, PLRU_MAX_LVL'(way_q), ICACHE_N_WAY);
      end

      assign plru_way    = vic_ext[WAY_W-1:0];
      // A commit to the same set owns that row this cycle; the hit is dropped.
      assign hit_apply   = hit_valid_i && !(commit_fire && (hit_set_i == set_q));
      assign unused_plru = ^{vic_ext, hit_upd, com_upd};

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            for (int s = 0; s < ICACHE_N_SETS; s++) plru_q[s] <= '0;
         end else if (flush_i) begin
            for (int s = 0; s < ICACHE_N_SETS; s++) plru_q[s] <= '0;
         end else begin
            if (hit_apply)   plru_q[hit_set_i] <= hit_upd[ICACHE_N_WAY-2:0];
            if (commit_fire) plru_q[set_q]     <= com_upd[ICACHE_N_WAY-2:0];
         end
      end
   end else begin : g_no_plru
      logic unused_plru;
      assign plru_way    = '0;
      assign unused_plru = ^{hit_valid_i, hit_set_i, hit_way_i, set_q};
   end

endmodule

// File: doc/sargantana_icache_replace.md
Name: sargantana_icache_replace

Overview:
Parametrised instruction-cache victim-way selector that replaces the fixed 8-bit LFSR way picker. It supports a configurable-width LFSR random policy or a per-set tree pseudo-LRU policy, and gives priority to invalid ways. A refill request is answered with a registered victim offer that is held until the refill FSM commits it. It sits between the icache tag/valid array and the refill controller.

Parameters:
ICACHE_N_WAY, 4, number of ways; power of two, >= 2
ICACHE_N_SETS, 64, number of sets; power of two
REPL_POLICY, 0, 0 = LFSR random, 1 = tree PLRU
LFSR_WIDTH, 8, LFSR length; one of {4, 8, 12, 16}; must be >= $clog2(ICACHE_N_WAY)
LFSR_SEED, 0, LFSR reset value; must not be all-ones (elaboration assertion)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  clear PLRU state, abort pending offer
hit_valid_i  in  1  lookup hit; update PLRU for this access
hit_set_i  in  $clog2(ICACHE_N_SETS)  set of hit
hit_way_i  in  $clog2(ICACHE_N_WAY)  way of hit
refill_req_i  in  1  request a victim (single-cycle pulse)
refill_set_i  in  $clog2(ICACHE_N_SETS)  set needing refill
valid_ways_i  in  ICACHE_N_WAY  valid bits of refill_set_i, sampled with refill_req_i
refill_valid_o  out  1  victim offer valid
refill_way_o  out  $clog2(ICACHE_N_WAY)  offered victim way
refill_commit_i  in  1  refill controller accepts the offer

Behaviour:
- Reset (async, rst_ni = 0): FSM = IDLE; refill_valid_o = 0; refill_way_o = 0; LFSR = LFSR_SEED; all PLRU bits = 0.
- FSM IDLE:
  - refill_req_i = 1 -> OFFER at the next edge.
  - refill_way_o is registered; its value is computed from the state present in the request cycle.
  - refill_valid_o = 1 exactly one cycle after the request.
- FSM OFFER: refill_valid_o and refill_way_o are held stable.
  - refill_req_i is ignored.
  - refill_commit_i = 1 -> IDLE.
  - refill_commit_i while IDLE is ignored.
- Victim selection (in the request cycle):
  - If any valid_ways_i bit is 0, select the lowest-index invalid way, regardless of policy.
  - Otherwise, under LFSR, select LFSR state bits [$clog2(ICACHE_N_WAY)-1:0].
  - Otherwise, under PLRU, walk the tree of refill_set_i.
- LFSR: Fibonacci, XNOR feedback, shift-left, feedback bit inserted at bit 0.
  - Taps come from a package function, in 0-indexed bits:
    - width 4: {3,2}
    - width 8: {7,5,4,3}
    - width 12: {11,5,3,0}
    - width 16: {15,14,12,3}
  - Advances one step on each commit only, independent of policy; it is not advanced by requests or hits.
  - flush_i does not alter the LFSR.
- PLRU: ICACHE_N_WAY-1 bits per set. Node 0 is the root; the children of node i are 2i+1 and 2i+2.
  - Victim walk: bit = 0 goes left, bit = 1 goes right.
  - Access update: every node on the path to the accessed way is set to point away from it.
  - Updated on a hit (hit_set_i, hit_way_i) and on a commit (the offered set and way).
  - Only ICACHE_N_SETS x (ICACHE_N_WAY-1) flops are kept, and only when REPL_POLICY = 1; otherwise none.
- Simultaneous events:
  - Hit and commit to different sets: both updates apply in the same edge.
  - Hit and commit to the same set: the commit update wins and the hit update is dropped.
  - Request and commit in the same cycle: the commit is processed and the request is dropped, because the FSM is in OFFER.
  - flush_i has priority over every other event: PLRU cleared, FSM -> IDLE, refill_valid_o = 0 next cycle, and same-cycle hit, commit and request are dropped.
- The offered set index is registered with the offer, for the commit update.

Decomposition:
- Package sargantana_icache_repl_pkg: repl_policy_e enum (REPL_LFSR, REPL_PLRU), function lfsr_taps(width) returning the tap mask, PLRU victim function and PLRU update function (parametrised by the way count).
- One sub-module: sargantana_icache_lfsr_n (parametrised width, seed and enable; exposes the full state).
- The FSM and the PLRU array stay in the top module.

Test Plan:
- LFSR policy, 8-bit, seed 0, N_WAY = 4, valid_ways_i = 4'b1111; six request/commit pairs -> refill_way_o = 0, 1, 3, 3, 3, 2 (LFSR states 0x00, 0x01, 0x03, 0x07, 0x0F, 0x1E).
- Invalid priority: valid_ways_i = 4'b1011 under each policy -> refill_way_o = 2; valid_ways_i = 4'b0000 -> refill_way_o = 0.
- PLRU, set 5, all valid, four request/commit pairs from reset -> offers 0, 2, 1, 3; set 6 is still offered 0 afterwards.
- Hit/commit collision: an offer of way 0 is pending for set 5; hit on set 5 way 3 in the same cycle as the commit -> the next set 5 offer is way 2 (hit dropped). Repeat with the hit on set 7 -> both updates apply, and the next set 7 offer is way 0.
- Handshake: refill_req_i at cycle t -> refill_valid_o = 1 at t+1; the offer is held stable for 5 cycles without a commit; a second request during the offer has no effect; commit -> refill_valid_o = 0 the next cycle.
- flush_i during OFFER -> refill_valid_o = 0 the next cycle and PLRU reset (next offer way 0), with the LFSR state unchanged. Assert rst_ni mid-offer -> outputs go to 0 immediately (async) and the LFSR returns to LFSR_SEED.
